qed_replay_buffer: RTL and testbench
====================================

# qed_replay_buffer

Duplicate-generation stage of the SQED harness, sitting directly downstream of the instruction constraint block and upstream of the core's fetch port. It issues constrained original instructions to the core while recording them, then, on request or when full, replays each recorded instruction as its register- and memory-remapped duplicate. Once every original has been duplicated, it signals that the architectural-state consistency check may fire.

## Interface
- DEPTH, 16: recorded-instruction capacity; power of two, at least 2.
- PTR_W, 4: log2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  core accepts an instruction this cycle; all state changes are qualified by ena.
- exec_dup  in  1  free formal input requesting the switch to the duplicate phase.
- ifu_qed_instruction  in  32  constrained original instruction: I-type ALU, R-type ALU/MUL, LW/SW with rs1=x0 and imm[11:10]=00, or NOP (opcode 7'h7F); all registers < 16.
- qed_instruction  out  32  instruction delivered to the core.
- qed_vld_out  out  1  qed_instruction was produced by an accepted cycle.
- qed_ready  out  1  all recorded originals have been duplicated.
- num_orig  out  PTR_W+1  originals recorded.
- num_dup  out  PTR_W+1  duplicates issued.

## Operation
- States: ORIG (reset state), DUP, DONE. DONE is sticky until reset.
- Buffer: a DEPTH-entry circular FIFO with PTR_W-bit read and write pointers plus a PTR_W+1-bit occupancy count. Pointers wrap modulo DEPTH.
- Per ena cycle, the block decides whether to duplicate:
  - do_dup = (state==DUP) || (state==ORIG && count!=0 && (exec_dup || count==DEPTH)).
  - do_orig = (state==ORIG) && !do_dup.
- do_orig:
  - Output ifu_qed_instruction unchanged.
  - Push it into the FIFO and increment num_orig.
- do_dup:
  - Pop the FIFO head and output its duplicate transform. Increment num_dup.
  - Enter DUP if coming from ORIG.
  - If this pop empties the FIFO, next state is DONE.
- exec_dup with count==0 is ignored; the cycle is a normal do_orig.
- Full FIFO in ORIG forces do_dup, so the FIFO can never overflow.
- Duplicate transform, selected by opcode of the popped entry:
  - R-type (0110011): set bit 4 of rd, rs1 and rs2.
  - I-type (0010011): set bit 4 of rd and rs1.
  - LW (0000011): set bit 4 of rd; rs1 unchanged; set instruction[30] (imm[10], +1024 byte offset into the duplicate memory half).
  - SW (0100011): set bit 4 of rs2; rs1 unchanged; set instruction[30].
  - NOP and any other opcode: unchanged.
- DONE: output NOP 32'h0000007F with qed_vld_out=0 on every cycle.
- Width rules: num_orig and num_dup saturate at DEPTH. Because the FIFO count cannot exceed DEPTH, neither counter can exceed it either.

## Timing
- qed_instruction and qed_vld_out are registered, so latency from an accepted input to output is 1 cycle.
- ena low: qed_instruction holds its value; qed_vld_out=0 next cycle; FIFO, state and counters are unchanged; exec_dup is ignored.
- qed_ready is registered; it is 1 on the cycle after DONE is entered, and only when num_orig==num_dup.
- Reset (asynchronous, any time, including mid-DUP):
  - qed_instruction=32'h0000007F; qed_vld_out=0; qed_ready=0.
  - num_orig=0; num_dup=0; pointers and count cleared; state=ORIG.
- FIFO contents are not reset.

## Configuration
- QED_NOP_FILTER_EN defined: in ORIG, NOP originals are issued but neither pushed nor counted. Consequently, exec_dup and the full condition only consider non-NOP entries.
- QED_NOP_FILTER_EN undefined: NOPs are recorded and replayed like any other instruction.

## Test plan
- Reset then 3 ena cycles of ADD x1,x2,x3 (32'h003100B3), then exec_dup=1 -> next 3 outputs are 32'h013908B3, num_dup=3, then qed_ready=1 and NOP output with qed_vld_out=0.
- LW x5,8(x0) (32'h00802283) recorded then replayed -> duplicate 32'h40802A83; SW x6,4(x0) (32'h00602223) -> duplicate 32'h41602223.
- Hold exec_dup=0 for 16 accepted originals -> the 17th ena cycle issues the first duplicate; num_orig stays 16.
- exec_dup=1 from reset with empty FIFO -> the original is issued, state stays ORIG, num_orig=1.
- ena=0 for 4 cycles mid-DUP -> qed_instruction held, qed_vld_out=0, num_dup unchanged. Deasserting rst_n mid-DUP -> all outputs take their reset values immediately.
- With QED_NOP_FILTER_EN: pattern NOP, ADDI, NOP then exec_dup -> num_orig=1 and one duplicate issued. Without the macro -> num_orig=3 and 3 duplicates issued.

Source files
------------

// File: rtl/qed_replay_buffer.sv
// qed_replay_buffer: records constrained originals and replays them as remapped duplicates (optional QED_NOP_FILTER_EN skips NOP recording)
module qed_replay_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             exec_dup,
    input  logic [31:0]      ifu_qed_instruction,
    output logic [31:0]      qed_instruction,
    output logic             qed_vld_out,
    output logic             qed_ready,
    output logic [PTR_W:0]   num_orig,
    output logic [PTR_W:0]   num_dup
);
    localparam logic [31:0]  NOP  = 32'h0000_007F;
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE  = (PTR_W+1)'(1);

    typedef enum logic [1:0] {ORIG, DUP, DONE} state_t;

    state_t           state, state_next;
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_dup, do_orig, record;
    logic [31:0]      head, dup_instr, out_next;

    // Duplicate transform of the FIFO head: bit 4 of each remapped register, bit 30 moves memory into the upper half
    always_comb begin
        head      = mem[rd_ptr];
        dup_instr = head;
        case (head[6:0])
            7'b0110011: dup_instr = head | 32'h0108_0800;
            7'b0010011: dup_instr = head | 32'h0008_0800;
            7'b0000011: dup_instr = head | 32'h4000_0800;
            7'b0100011: dup_instr = head | 32'h4100_0000;
            default:    dup_instr = head;
        endcase
    end

    // Phase decision, next state and next output word
    always_comb begin
        do_dup     = ena && (state == DUP ||
                     (state == ORIG && count != '0 && (exec_dup || count == FULL)));
        do_orig    = ena && state == ORIG && !do_dup;
`ifdef QED_NOP_FILTER_EN
        record     = do_orig && ifu_qed_instruction[6:0] != 7'h7F;
`else
        record     = do_orig;
`endif
        state_next = do_dup ? (count == ONE ? DONE : DUP) : state;
        out_next   = state == DONE ? NOP : do_dup ? dup_instr : ifu_qed_instruction;
    end

    // State, pointers, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ORIG;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            num_orig        <= '0;
            num_dup         <= '0;
            qed_instruction <= NOP;
            qed_vld_out     <= 1'b0;
            qed_ready       <= 1'b0;
        end else begin
            state       <= state_next;
            qed_ready   <= state == DONE && num_orig == num_dup;
            qed_vld_out <= do_dup || do_orig;
            if (ena)
                qed_instruction <= out_next;
            if (record) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
                if (num_orig != FULL)
                    num_orig <= num_orig + 1'b1;
            end else if (do_dup) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
                if (num_dup != FULL)
                    num_dup <= num_dup + 1'b1;
            end
        end
    end

    // Instruction storage, deliberately left unreset
    always_ff @(posedge clk) begin
        if (record)
            mem[wr_ptr] <= ifu_qed_instruction;
    end
endmodule

// File: tb/tb_qed_replay_buffer.sv
// tb_qed_replay_buffer: directed and randomized checks of the replay buffer against a queue model
module tb_qed_replay_buffer;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;
    localparam logic [31:0] NOP  = 32'h0000_007F;
    localparam logic [31:0] ADD  = 32'h003100B3;
    localparam logic [31:0] ADDI = 32'h00500093;
`ifdef QED_NOP_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b0, exec_dup = 1'b0;
    logic [31:0] ifu = NOP;
    logic [31:0] qed_instruction;
    logic        qed_vld_out, qed_ready;
    logic [PTR_W:0] num_orig, num_dup;

    qed_replay_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .exec_dup(exec_dup),
        .ifu_qed_instruction(ifu), .qed_instruction(qed_instruction),
        .qed_vld_out(qed_vld_out), .qed_ready(qed_ready),
        .num_orig(num_orig), .num_dup(num_dup)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    logic [31:0] q[$];
    int          phase;
    logic [31:0] m_out;
    logic        m_vld, m_ready;
    logic [PTR_W:0] m_norig, m_ndup;

    function automatic logic [31:0] dupx(input logic [31:0] i);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        rd  = i[11:7];
        rs1 = i[19:15];
        rs2 = i[24:20];
        case (i[6:0])
            7'h33: return {i[31:25], rs2 + 5'd16, rs1 + 5'd16, i[14:12], rd + 5'd16, i[6:0]};
            7'h13: return {i[31:20], rs1 + 5'd16, i[14:12], rd + 5'd16, i[6:0]};
            7'h03: begin
                imm = i[31:20] + 12'd1024;
                return {imm, i[19:12], rd + 5'd16, i[6:0]};
            end
            7'h23: begin
                imm = {i[31:25], i[11:7]} + 12'd1024;
                return {imm[11:5], rs2 + 5'd16, i[19:12], imm[4:0], i[6:0]};
            end
            default: return i;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr(input bit allow_nop);
        logic [4:0] rd, rs1, rs2;
        int k;
        rd  = 5'($urandom_range(0, 15));
        rs1 = 5'($urandom_range(0, 15));
        rs2 = 5'($urandom_range(0, 15));
        k   = $urandom_range(0, allow_nop ? 4 : 3);
        case (k)
            0: return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h01, rs2, rs1, 3'($urandom_range(0, 7)), rd, 7'h33};
            1: return {12'($urandom), rs1, 3'($urandom_range(0, 7)), rd, 7'h13};
            2: return {2'b00, 10'($urandom), 5'd0, 3'b010, rd, 7'h03};
            3: return {2'b00, 5'($urandom), rs2, 5'd0, 3'b010, 5'($urandom), 7'h23};
            default: return NOP;
        endcase
    endfunction

    task automatic model_step(input logic e, input logic x, input logic [31:0] ins);
        logic nr;
        bit   d;
        nr = phase == 2 && m_norig == m_ndup;
        if (e) begin
            d = phase == 1 || (phase == 0 && q.size() > 0 && (x || q.size() == DEPTH));
            if (phase == 2) begin
                m_out = NOP;
                m_vld = 1'b0;
            end else if (d) begin
                m_out  = dupx(q.pop_front());
                m_vld  = 1'b1;
                m_ndup = m_ndup + 1'b1;
                phase  = q.size() == 0 ? 2 : 1;
            end else begin
                m_out = ins;
                m_vld = 1'b1;
                if (!(FILTER && ins[6:0] == 7'h7F)) begin
                    q.push_back(ins);
                    m_norig = m_norig + 1'b1;
                end
            end
        end else
            m_vld = 1'b0;
        m_ready = nr;
    endtask

    task automatic cycle(input logic e, input logic x, input logic [31:0] ins);
        ena = e;
        exec_dup = x;
        ifu = ins;
        model_step(e, x, ins);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        ena = 1'b0;
        exec_dup = 1'b0;
        q.delete();
        phase = 0;
        m_out = NOP;
        m_vld = 1'b0;
        m_ready = 1'b0;
        m_norig = '0;
        m_ndup = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({qed_instruction, qed_vld_out, qed_ready, num_orig, num_dup} !== {NOP, 1'b0, 1'b0, 5'd0, 5'd0}) begin
            failures++;
            $display("FAIL reset: ins=%h vld=%b rdy=%b no=%0d nd=%0d want ins=0000007f, all else 0",
                     qed_instruction, qed_vld_out, qed_ready, num_orig, num_dup);
        end
    endtask

    task automatic test_add_replay();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, i >= 3, ADD);
            checks++;
            if ({qed_instruction, qed_vld_out, num_orig, num_dup} !== {m_out, m_vld, m_norig, m_ndup}) begin
                failures++;
                $display("FAIL add_model[%0d]: ins=%h vld=%b no=%0d nd=%0d want %h %b %0d %0d",
                         i, qed_instruction, qed_vld_out, num_orig, num_dup, m_out, m_vld, m_norig, m_ndup);
            end
            if (i >= 3) begin
                checks++;
                if (qed_instruction !== 32'h013908B3 || qed_vld_out !== 1'b1) begin
                    failures++;
                    $display("FAIL add_dup[%0d]: ins=%h vld=%b want 013908b3 1", i, qed_instruction, qed_vld_out);
                end
            end
        end
        checks++;
        if (num_dup !== 5'd3 || num_orig !== 5'd3) begin
            failures++;
            $display("FAIL add_counts: no=%0d nd=%0d want 3 3", num_orig, num_dup);
        end
        cycle(1'b1, 1'b0, ADD);
        checks++;
        if ({qed_instruction, qed_vld_out, qed_ready} !== {NOP, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL add_done: ins=%h vld=%b rdy=%b want 0000007f 0 1", qed_instruction, qed_vld_out, qed_ready);
        end
    endtask

    task automatic test_lw_sw();
        apply_reset();
        cycle(1'b1, 1'b0, 32'h00802283);
        cycle(1'b1, 1'b0, 32'h00602223);
        cycle(1'b1, 1'b1, ADD);
        checks++;
        if (qed_instruction !== 32'h40802A83) begin
            failures++;
            $display("FAIL lw_dup: ins=%h want 40802a83", qed_instruction);
        end
        cycle(1'b1, 1'b0, ADD);
        checks++;
        if (qed_instruction !== 32'h41602223 || num_dup !== 5'd2) begin
            failures++;
            $display("FAIL sw_dup: ins=%h nd=%0d want 41602223 2", qed_instruction, num_dup);
        end
    endtask

    task automatic test_full();
        logic [31:0] first, ins;
        apply_reset();
        first = rand_instr(1'b0);
        cycle(1'b1, 1'b0, first);
        for (int i = 1; i < DEPTH; i++) cycle(1'b1, 1'b0, rand_instr(1'b0));
        checks++;
        if (num_orig !== 5'd16 || num_dup !== 5'd0 || qed_vld_out !== 1'b1) begin
            failures++;
            $display("FAIL full_fill: no=%0d nd=%0d vld=%b want 16 0 1", num_orig, num_dup, qed_vld_out);
        end
        ins = rand_instr(1'b0);
        cycle(1'b1, 1'b0, ins);
        checks++;
        if (qed_instruction !== dupx(first) || qed_vld_out !== 1'b1 || num_orig !== 5'd16 || num_dup !== 5'd1) begin
            failures++;
            $display("FAIL full_force: ins=%h vld=%b no=%0d nd=%0d want %h 1 16 1",
                     qed_instruction, qed_vld_out, num_orig, num_dup, dupx(first));
        end
    endtask

    task automatic test_exec_empty();
        logic [31:0] a, b;
        apply_reset();
        a = rand_instr(1'b0);
        b = rand_instr(1'b0);
        cycle(1'b1, 1'b1, a);
        checks++;
        if (qed_instruction !== a || qed_vld_out !== 1'b1 || num_orig !== 5'd1 || num_dup !== 5'd0) begin
            failures++;
            $display("FAIL exec_empty: ins=%h vld=%b no=%0d nd=%0d want %h 1 1 0",
                     qed_instruction, qed_vld_out, num_orig, num_dup, a);
        end
        cycle(1'b1, 1'b0, b);
        checks++;
        if (qed_instruction !== b || num_orig !== 5'd2) begin
            failures++;
            $display("FAIL exec_empty_orig: ins=%h no=%0d want %h 2", qed_instruction, num_orig, b);
        end
    endtask

    task automatic test_ena_hold_and_reset();
        logic [31:0] held;
        logic [PTR_W:0] nd;
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, rand_instr(1'b0));
        cycle(1'b1, 1'b1, ADD);
        held = qed_instruction;
        nd = num_dup;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, rand_instr(1'b1));
            checks++;
            if (qed_instruction !== held || qed_vld_out !== 1'b0 || num_dup !== nd || nd !== 5'd1) begin
                failures++;
                $display("FAIL ena_hold[%0d]: ins=%h vld=%b nd=%0d want %h 0 1", i, qed_instruction, qed_vld_out, num_dup, held);
            end
        end
        cycle(1'b1, 1'b0, ADD);
        checks++;
        if (qed_instruction !== m_out || num_dup !== 5'd2 || qed_vld_out !== 1'b1) begin
            failures++;
            $display("FAIL ena_resume: ins=%h nd=%0d vld=%b want %h 2 1", qed_instruction, num_dup, qed_vld_out, m_out);
        end
        ena = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({qed_instruction, qed_vld_out, qed_ready, num_orig, num_dup} !== {NOP, 1'b0, 1'b0, 5'd0, 5'd0}) begin
            failures++;
            $display("FAIL async_reset: ins=%h vld=%b rdy=%b no=%0d nd=%0d want 0000007f 0 0 0 0",
                     qed_instruction, qed_vld_out, qed_ready, num_orig, num_dup);
        end
        apply_reset();
        cycle(1'b1, 1'b0, ADD);
        checks++;
        if (qed_instruction !== ADD || num_orig !== 5'd1 || num_dup !== 5'd0) begin
            failures++;
            $display("FAIL post_reset_orig: ins=%h no=%0d nd=%0d want %h 1 0", qed_instruction, num_orig, num_dup, ADD);
        end
    endtask

    task automatic test_nop_pattern();
        logic [PTR_W:0] want;
        want = FILTER ? 5'd1 : 5'd3;
        apply_reset();
        cycle(1'b1, 1'b0, NOP);
        cycle(1'b1, 1'b0, ADDI);
        cycle(1'b1, 1'b0, NOP);
        checks++;
        if (num_orig !== want || qed_instruction !== NOP || qed_vld_out !== 1'b1) begin
            failures++;
            $display("FAIL nop_record: no=%0d ins=%h vld=%b want %0d 0000007f 1", num_orig, qed_instruction, qed_vld_out, want);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, ADDI);
        checks++;
        if (num_dup !== want || num_orig !== want || qed_ready !== 1'b1) begin
            failures++;
            $display("FAIL nop_replay: no=%0d nd=%0d rdy=%b want %0d %0d 1", num_orig, num_dup, qed_ready, want, want);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            apply_reset();
            for (int c = 0; c < 70; c++) begin
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, rand_instr(1'b1));
                checks++;
                if ({qed_instruction, qed_vld_out, qed_ready, num_orig, num_dup} !== {m_out, m_vld, m_ready, m_norig, m_ndup}) begin
                    failures++;
                    $display("FAIL random[%0d.%0d]: ins=%h vld=%b rdy=%b no=%0d nd=%0d want %h %b %b %0d %0d",
                             r, c, qed_instruction, qed_vld_out, qed_ready, num_orig, num_dup,
                             m_out, m_vld, m_ready, m_norig, m_ndup);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_replay();
        test_lw_sw();
        test_full();
        test_exec_empty();
        test_ena_hold_and_reset();
        test_nop_pattern();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
